// File: rtl/isr_seq_pkg.sv
// isr_seq_pkg: shared state encoding and config field positions for the interrupt sequencer.
package isr_seq_pkg;
  typedef enum logic [1:0] {IDLE, TAKE, ISR, RET} isr_state_t;
  localparam int MASK_LSB = 0;
  function automatic int ie_bit(input int num_src);
    return num_src;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q;
  always_ff @(posedge clk or negedge clr)
    if (!clr) count_q <= '0;
    else if (inc && !(&count_q)) count_q <= count_q + 1'b1;
  assign count = count_q;
endmodule

// File: rtl/isr_sequencer.sv
// isr_sequencer: takes an interrupt at an instruction boundary, redirects to the vector,
// blocks further interrupts until reti, then restores the saved return PC.
module isr_sequencer
  import isr_seq_pkg::*;
#(
  parameter int PC_WIDTH  = 8,
  parameter int NUM_SRC   = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 i_pending,
  input  logic [PC_WIDTH-1:0]  vec_pc,
  input  logic [PC_WIDTH-1:0]  pc_in,
  input  logic                 instr_boundary,
  input  logic                 reti,
  input  logic                 cfg_we,
  input  logic [NUM_SRC:0]     cfg_wdata,
  output logic                 enable_out,
  output logic [NUM_SRC-1:0]   mask_out,
  output logic                 i_clr,
  output logic                 pc_load,
  output logic [PC_WIDTH-1:0]  pc_load_val,
  output logic                 stall,
  output logic                 in_isr,
  output logic [CNT_WIDTH-1:0] irq_count,
  output logic                 spurious_reti
);
  localparam int IeBit = ie_bit(NUM_SRC);
  isr_state_t state_q, state_d;
  logic ie_q, spur_q, take;
  logic [NUM_SRC-1:0] mask_q;
  logic [PC_WIDTH-1:0] epc_q, vec_q;
  assign enable_out = ie_q && state_q == IDLE;
  assign take = i_pending && enable_out && instr_boundary;
  always_comb
    state_d = (state_q == IDLE) ? (take ? TAKE : IDLE) :
              (state_q == TAKE) ? ISR :
              (state_q == ISR)  ? (reti ? RET : ISR) : IDLE;
  // Config writes land even on a take cycle; the take already used the old ie.
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state_q <= IDLE;
      ie_q    <= 1'b0;
      mask_q  <= '0;
      epc_q   <= '0;
      vec_q   <= '0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cfg_we) begin
        ie_q   <= cfg_wdata[IeBit];
        mask_q <= cfg_wdata[MASK_LSB +: NUM_SRC];
      end
      if (take) begin
        epc_q <= pc_in;
        vec_q <= vec_pc;
      end
      if (reti && state_q != ISR) spur_q <= 1'b1;
    end
  assign mask_out      = mask_q;
  assign pc_load       = state_q == TAKE || state_q == RET;
  assign stall         = pc_load;
  assign i_clr         = state_q == TAKE;
  assign in_isr        = state_q == ISR;
  assign spurious_reti = spur_q;
  assign pc_load_val   = (state_q == TAKE) ? vec_q : (state_q == RET) ? epc_q : '0;
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
    .clk  (clk),
    .clr  (clr),
    .inc  (state_q == TAKE),
    .count(irq_count)
  );
endmodule

// File: tb/tb_isr_sequencer.sv
// tb_isr_sequencer: directed stimulus with a scoreboard of expected PC redirects.
module tb_isr_sequencer;
  logic clk = 0, clr = 0, i_pending = 0, instr_boundary = 0, reti = 0, cfg_we = 0;
  logic [7:0] vec_pc = 0, pc_in = 0;
  logic [4:0] cfg_wdata = 0;
  logic enable_out, i_clr, pc_load, stall, in_isr, spurious_reti;
  logic [3:0] mask_out;
  logic [7:0] pc_load_val, irq_count;
  int total = 0, bad = 0;
  typedef struct packed {logic [7:0] val; logic clr;} exp_t;
  exp_t sb[$];

  isr_sequencer dut (
    .clk(clk), .clr(clr), .i_pending(i_pending), .vec_pc(vec_pc), .pc_in(pc_in),
    .instr_boundary(instr_boundary), .reti(reti), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata),
    .enable_out(enable_out), .mask_out(mask_out), .i_clr(i_clr), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .stall(stall), .in_isr(in_isr), .irq_count(irq_count),
    .spurious_reti(spurious_reti)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v, input logic c);
    sb.push_back('{val: v, clr: c});
  endtask

  task automatic cfg(input logic [4:0] w);
    cfg_we = 1;
    cfg_wdata = w;
    step();
    cfg_we = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pc_load) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pc_load got=%0d required=none at %0t", pc_load_val, $time);
      end else begin
        e = sb.pop_front();
        chk("pc_load_val", pc_load_val, e.val);
        chk("i_clr_with_load", i_clr, e.clr);
      end
    end else chk("idle_pc_load_val", pc_load_val, 0);
  end

  initial begin
    #12;
    chk("rst_enable", enable_out, 0);
    chk("rst_mask", mask_out, 0);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_stall", stall, 0);
    chk("rst_in_isr", in_isr, 0);
    chk("rst_count", irq_count, 0);
    chk("rst_spur", spurious_reti, 0);
    step();
    clr = 1;
    cfg(5'b11111);
    chk("cfg_mask", mask_out, 4'hf);
    chk("cfg_enable", enable_out, 1);
    // basic take and return
    i_pending = 1; instr_boundary = 1; vec_pc = 230; pc_in = 42;
    push(230, 1);
    step();
    i_pending = 0;
    chk("take_stall", stall, 1);
    chk("take_enable", enable_out, 0);
    chk("take_i_clr", i_clr, 1);
    step();
    chk("isr_in_isr", in_isr, 1);
    chk("isr_count1", irq_count, 1);
    reti = 1;
    push(42, 0);
    step();
    reti = 0;
    chk("ret_stall", stall, 1);
    chk("ret_in_isr", in_isr, 0);
    step();
    chk("ret_idle_enable", enable_out, 1);
    chk("ret_spur", spurious_reti, 0);
    // disabled
    cfg(5'b01111);
    i_pending = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("dis_pc_load", pc_load, 0);
      chk("dis_in_isr", in_isr, 0);
    end
    i_pending = 0;
    cfg(5'b11111);
    // boundary gating
    i_pending = 1; instr_boundary = 0; vec_pc = 99;
    for (int i = 0; i < 5; i++) begin
      pc_in = 8'(10 + i);
      step();
      chk("gate_stall", stall, 0);
    end
    instr_boundary = 1; pc_in = 77;
    push(99, 1);
    step();
    i_pending = 0; instr_boundary = 0; pc_in = 5;
    chk("gate_take", stall, 1);
    step();
    reti = 1;
    push(77, 0);
    step();
    reti = 0;
    step();
    // no nesting
    i_pending = 1; instr_boundary = 1; vec_pc = 50; pc_in = 60;
    push(50, 1);
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      chk("nest_enable", enable_out, 0);
      chk("nest_in_isr", in_isr, 1);
      step();
    end
    reti = 1;
    push(60, 0);
    step();
    reti = 0; vec_pc = 51; pc_in = 61;
    push(51, 1);
    step();
    chk("nest_idle_enable", enable_out, 1);
    step();
    i_pending = 0;
    chk("nest_retake", i_clr, 1);
    step();
    chk("nest_count", irq_count, 4);
    reti = 1;
    push(61, 0);
    step();
    reti = 0;
    step();
    // stray reti
    reti = 1;
    step();
    reti = 0;
    chk("spur_flag", spurious_reti, 1);
    chk("spur_stall", stall, 0);
    chk("spur_idle", enable_out, 1);
    step();
    chk("spur_sticky", spurious_reti, 1);
    // config write together with a take
    i_pending = 1; instr_boundary = 1; vec_pc = 200; pc_in = 100;
    cfg_we = 1; cfg_wdata = 5'b00000;
    push(200, 1);
    step();
    cfg_we = 0; i_pending = 0;
    chk("sim_mask", mask_out, 0);
    step();
    reti = 1;
    push(100, 0);
    step();
    reti = 0;
    step();
    chk("sim_enable_after", enable_out, 0);
    chk("sim_count", irq_count, 5);
    cfg(5'b11111);
    // saturation
    for (int i = 0; i < 300; i++) begin
      i_pending = 1; vec_pc = 8'(i); pc_in = ~8'(i);
      push(8'(i), 1);
      step();
      i_pending = 0;
      step();
      reti = 1;
      push(~8'(i), 0);
      step();
      reti = 0;
      step();
    end
    chk("sat_count", irq_count, 255);
    // reset mid-ISR
    i_pending = 1; vec_pc = 33; pc_in = 44;
    push(33, 1);
    step();
    i_pending = 0;
    step();
    chk("mid_in_isr", in_isr, 1);
    #2 clr = 0;
    #1;
    chk("mid_in_isr_rst", in_isr, 0);
    chk("mid_count_rst", irq_count, 0);
    chk("mid_spur_rst", spurious_reti, 0);
    chk("mid_mask_rst", mask_out, 0);
    chk("mid_pc_load_rst", pc_load, 0);
    @(negedge clk);
    clr = 1;
    i_pending = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_enable", enable_out, 0);
      chk("post_pc_load", pc_load, 0);
    end
    i_pending = 0;
    step();
    chk("queue_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/isr_sequencer.md
# isr_sequencer

- Sequences the maskable vectored priority interrupt unit on behalf of the processor control path.
- Owns the unit's `mask_in`, `enable` and `i_clr` inputs; watches its `i_pending` and `PC_out` outputs.
- Waits for an instruction boundary, saves the return PC, redirects the PC to the ISR vector and clears the pending register.
- Holds interrupts off until the ISR signals return, then restores the saved PC.

## Interface

Parameters:
- `PC_WIDTH`, 8: program counter / vector width.
- `NUM_SRC`, 4: number of interrupt sources (mask width).
- `CNT_WIDTH`, 8: taken-interrupt counter width.

Ports:
- `clk` in 1: system clock, rising edge.
- `clr` in 1: reset; asynchronous, active-low.
- `i_pending` in 1: interrupt pending from the interrupt unit (combinational there).
- `vec_pc` in PC_WIDTH: ISR vector from the interrupt unit.
- `pc_in` in PC_WIDTH: current PC of the next instruction to execute.
- `instr_boundary` in 1: high in cycles where the core may be redirected.
- `reti` in 1: one-cycle pulse, return-from-interrupt executed.
- `cfg_we` in 1: configuration write strobe.
- `cfg_wdata` in NUM_SRC+1: {ie, mask[NUM_SRC-1:0]}.
- `enable_out` out 1: drives the interrupt unit's `enable`.
- `mask_out` out NUM_SRC: drives the interrupt unit's `mask_in`.
- `i_clr` out 1: drives the interrupt unit's `i_clr`.
- `pc_load` out 1: PC redirect strobe to the core.
- `pc_load_val` out PC_WIDTH: redirect target.
- `stall` out 1: freeze fetch while redirecting.
- `in_isr` out 1: ISR currently active.
- `irq_count` out CNT_WIDTH: saturating count of taken interrupts.
- `spurious_reti` out 1: sticky error flag, `reti` seen outside an ISR.

## Operation

- **Registers:** `ie` and `mask` are written by `cfg_we`, with the new value effective the next cycle.
- **enable_out:** equals `ie` && state==IDLE, so interrupts cannot nest.
- **State IDLE:** if `i_pending` && `enable_out` && `instr_boundary`:
  - capture `epc` <= `pc_in` and `vec_q` <= `vec_pc`;
  - go to TAKE.
- **State TAKE** (exactly 1 cycle):
  - assert `pc_load`=1, `pc_load_val`=`vec_q`, `i_clr`=1, `stall`=1;
  - increment `irq_count`, saturating at all-ones;
  - go to ISR.
- **State ISR:**
  - `in_isr`=1, `enable_out`=0;
  - on `reti`, go to RET.
- **State RET** (exactly 1 cycle):
  - assert `pc_load`=1, `pc_load_val`=`epc`, `stall`=1;
  - go to IDLE.
- **Default outputs:** `pc_load_val`=0 whenever `pc_load`=0.
- **Clearing pending interrupts:** `i_clr` clears all pending sources. Lower-priority requests pending at TAKE are discarded by design; sources must reassert.
- **Stray `reti`:** `reti` in IDLE, TAKE or RET is ignored and sets `spurious_reti`. The flag is cleared only by reset.

## Timing

- **Reset:** while `clr`=0, state=IDLE, `ie`=0, `mask`=0, `epc`=0, `vec_q`=0, `irq_count`=0, and every output is 0.
- **Take latency:** condition true in IDLE at cycle N gives TAKE outputs in cycle N+1, ISR from N+2, and `enable_out` low from N+1.
- **Return latency:** `reti` in ISR at cycle M gives RET outputs in cycle M+1, IDLE at M+2, and `enable_out` restored at M+2 if `ie`=1.
  - A pending interrupt can be taken again at M+2 with a boundary.
- **Simultaneous `cfg_we` and take condition:** the take uses the old `ie`/`mask`. The write still lands.
- **`cfg_we` clearing `ie` during ISR:** `enable_out` stays 0 after RET.
- **`i_pending` drop:** if `i_pending` drops in the same cycle the take is evaluated, no take occurs. Once in TAKE the sequence completes regardless.
- **`instr_boundary` low:** the request waits in IDLE with no timeout.
- **Reset mid-ISR or mid-RET:** immediate return to reset values with no PC restore.

## Structure

- **Package `isr_seq_pkg`:**
  - state enum `isr_state_t` {IDLE, TAKE, ISR, RET};
  - constants for the `cfg_wdata` field positions (IE_BIT = NUM_SRC, MASK_LSB = 0).
- **Sub-module `sat_counter`:** parameterized width, `clk`/`clr`/`inc`/`count`, used for `irq_count`.
- **Top level:** the FSM plus the `epc`, `vec_q` and configuration registers. No other hierarchy.

## Test plan

- **Basic take and return:**
  - Stimulus: cfg write {1,4'b1111}; `i_pending`=1, `vec_pc`=230, `pc_in`=42, boundary=1 at cycle N.
  - Response: cycle N+1 has `pc_load`=1, `pc_load_val`=230, `i_clr`=1; `irq_count`=1.
  - Then `reti` at M: cycle M+1 has `pc_load_val`=42, and IDLE at M+2.
- **Interrupts disabled:** `ie`=0 with `i_pending`=1 for 20 cycles leaves `pc_load` 0 throughout and state IDLE.
- **Boundary gating:** pending with boundary low for 5 cycles, then high, gives TAKE exactly one cycle after the first boundary-high cycle; `epc` equals `pc_in` of that cycle.
- **No nesting:**
  - During ISR, `i_pending`=1 with boundary gives no TAKE and `enable_out`=0.
  - After RET, a second take occurs at M+2 and `irq_count`=2.
- **Spurious return and saturation:**
  - `reti` in IDLE sets `spurious_reti`=1 and leaves the state unchanged.
  - 300 takes leave `irq_count` at 255.
- **Reset mid-ISR:** `clr` low in ISR immediately forces all outputs and `irq_count` to 0; after release, the block stays in IDLE with `enable_out`=0.
